// File: rtl/temp_sensor_reader.sv
// SPI mode-0 sensor front end: one 16-bit frame per conversion -> clamped TN with a one-cycle TN_VALID strobe.
// No backpressure (TN is held, TN_VALID is a strobe); define TEMP_SENSOR_READER_MEDIAN3_EN for a 3-sample median filter.
module temp_sensor_reader #(
  parameter int CLK_DIV     = 4,
  parameter int IDLE_CYCLES = 8,
  parameter int TEMP_WIDTH  = 12,
  parameter int TEMP_MAX    = 100
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  EN,
  input  logic                  MISO,
  output logic                  SCLK,
  output logic                  CS_N,
  output logic [TEMP_WIDTH-1:0] TN,
  output logic                  TN_VALID,
  output logic                  FAULT
);

  localparam int CNT_MAX = (CLK_DIV > IDLE_CYCLES) ? CLK_DIV : IDLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(IDLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4:0]            half_q, half_d;
  logic [13:0]           shift_q, shift_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_n_q, cs_n_d;
  logic [TEMP_WIDTH-1:0] tn_q, tn_d;
  logic                  tn_valid_q, tn_valid_d;
  logic                  fault_q, fault_d;

  logic                  sign_bit, fault_bit;
  logic [11:0]           mag;
  logic [TEMP_WIDTH-1:0] clamped;

`ifdef TEMP_SENSOR_READER_MEDIAN3_EN
  logic [TEMP_WIDTH-1:0] win1_q, win1_d, win2_q, win2_d;
  logic [1:0]            fill_q, fill_d;

  function automatic logic [TEMP_WIDTH-1:0] med3(input logic [TEMP_WIDTH-1:0] a,
                                                 input logic [TEMP_WIDTH-1:0] b,
                                                 input logic [TEMP_WIDTH-1:0] c);
    logic [TEMP_WIDTH-1:0] lo, hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    if (c < lo)      return lo;
    else if (c > hi) return hi;
    else             return c;
  endfunction
`endif

  // Only frame bits 15..2 are kept: shift_q[13]=sign, [12:1]=magnitude, [0]=fault.
  always_comb begin
    sign_bit  = shift_q[13];
    mag       = shift_q[12:1];
    fault_bit = shift_q[0];
    if (sign_bit)                 clamped = '0;
    else if (int'(mag) > TEMP_MAX) clamped = TEMP_WIDTH'(TEMP_MAX);
    else                          clamped = TEMP_WIDTH'(mag);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    half_d     = half_q;
    shift_d    = shift_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    tn_d       = tn_q;
    tn_valid_d = 1'b0;
    fault_d    = fault_q;
`ifdef TEMP_SENSOR_READER_MEDIAN3_EN
    win1_d     = win1_q;
    win2_d     = win2_q;
    fill_d     = fill_q;
`endif
    case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        cs_n_d = 1'b1;
        // Counter saturates at GAP_LAST so a later EN starts a frame immediately.
        if (cnt_q == GAP_LAST) begin
          if (EN) begin
            state_d = SETUP;
            cnt_d   = '0;
            cs_n_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          half_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          // Rising edges fall on even half-periods; the last two carry ignored bits.
          if (!sclk_q && (half_q < 5'd28)) shift_d = {shift_q[12:0], MISO};
          if (half_q == 5'd31) begin
            state_d = DONE;
            cs_n_d  = 1'b1;
            half_d  = '0;
          end else begin
            half_d = half_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        if (fault_bit) begin
          fault_d = 1'b1;
        end else begin
          fault_d    = 1'b0;
          tn_valid_d = 1'b1;
`ifdef TEMP_SENSOR_READER_MEDIAN3_EN
          tn_d   = (fill_q == 2'd2) ? med3(clamped, win1_q, win2_q) : clamped;
          win1_d = clamped;
          win2_d = win1_q;
          fill_d = (fill_q == 2'd2) ? 2'd2 : fill_q + 2'd1;
`else
          tn_d = clamped;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      half_q     <= '0;
      shift_q    <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      tn_q       <= '0;
      tn_valid_q <= 1'b0;
      fault_q    <= 1'b0;
`ifdef TEMP_SENSOR_READER_MEDIAN3_EN
      win1_q     <= '0;
      win2_q     <= '0;
      fill_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      shift_q    <= shift_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      tn_q       <= tn_d;
      tn_valid_q <= tn_valid_d;
      fault_q    <= fault_d;
`ifdef TEMP_SENSOR_READER_MEDIAN3_EN
      win1_q     <= win1_d;
      win2_q     <= win2_d;
      fill_q     <= fill_d;
`endif
    end
  end

  assign SCLK     = sclk_q;
  assign CS_N     = cs_n_q;
  assign TN       = tn_q;
  assign TN_VALID = tn_valid_q;
  assign FAULT    = fault_q;

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Bench for temp_sensor_reader: behavioural SPI sensor plus a frame-level reference model.
module tb_temp_sensor_reader;

`ifdef TEMP_SENSOR_READER_MEDIAN3_EN
  localparam bit MED = 1'b1;
`else
  localparam bit MED = 1'b0;
`endif

  logic        CLK, RESET, EN, MISO;
  logic        SCLK, CS_N, TN_VALID, FAULT;
  logic [11:0] TN;

  temp_sensor_reader dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .MISO(MISO),
    .SCLK(SCLK), .CS_N(CS_N), .TN(TN), .TN_VALID(TN_VALID), .FAULT(FAULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Cycle bookkeeping: tick counts rising edges, base marks reset release.
  int tick = 0;
  int base = 0;
  bit rst_at_edge = 1'b1;
  always @(posedge CLK) begin
    tick++;
    rst_at_edge = RESET;
  end

  // Sensor and observation monitor, evaluated on the falling edge.
  logic [15:0] next_w = 16'h0000;
  logic [15:0] cur_w  = 16'h0000;
  int bit_idx = 15;
  int rise_cnt = 0, cslow_cnt = 0, glitch = 0, b2b = 0;
  logic sclk_prev = 1'b0, cs_prev = 1'b1, vld_prev = 1'b0;
  logic [11:0] tn_prev = '0;
  int frame_rises[$];
  int frame_cslow[$];
  int vld_cyc[$];
  int vld_tn[$];

  initial MISO = 1'b0;
  always @(negedge CLK) begin
    if (CS_N) begin
      bit_idx = 15;
      cur_w   = next_w;
    end else if (sclk_prev && !SCLK && bit_idx > 0) begin
      bit_idx--;
    end
    MISO = cur_w[bit_idx];
    if (!rst_at_edge) begin
      if (!sclk_prev && SCLK) rise_cnt++;
      if (!CS_N) cslow_cnt++;
      if (!cs_prev && CS_N) begin
        frame_rises.push_back(rise_cnt);
        frame_cslow.push_back(cslow_cnt);
        rise_cnt  = 0;
        cslow_cnt = 0;
      end
      if (TN_VALID) begin
        vld_cyc.push_back(tick - base);
        vld_tn.push_back(int'(TN));
      end
      if (TN !== tn_prev && !TN_VALID) glitch++;
      if (TN_VALID && vld_prev) b2b++;
    end else begin
      rise_cnt  = 0;
      cslow_cnt = 0;
    end
    sclk_prev = SCLK;
    cs_prev   = CS_N;
    tn_prev   = TN;
    vld_prev  = TN_VALID;
  end

  // Reference model: frame-level decode, clamp, and optional median of the last three accepted values.
  int acc[$];
  int exp_tn = 0;
  bit exp_fault = 0;
  bit exp_vld = 0;

  task automatic model_reset();
    acc.delete();
    exp_tn = 0;
    exp_fault = 0;
    exp_vld = 0;
  endtask

  task automatic model_frame(input logic [15:0] w);
    int v, n, a, b, c, mx, mn;
    if (w[2]) begin
      exp_fault = 1;
      exp_vld   = 0;
    end else begin
      if (w[15]) v = 0;
      else v = (int'(w[14:3]) > 100) ? 100 : int'(w[14:3]);
      acc.push_back(v);
      n = acc.size();
      if (MED && n >= 3) begin
        a = acc[n-1]; b = acc[n-2]; c = acc[n-3];
        mx = (a > b) ? a : b; mx = (mx > c) ? mx : c;
        mn = (a < b) ? a : b; mn = (mn < c) ? mn : c;
        exp_tn = a + b + c - mx - mn;
      end else begin
        exp_tn = v;
      end
      exp_fault = 0;
      exp_vld   = 1;
    end
  endtask

  task automatic reset_dut(input int n);
    RESET = 1'b1;
    repeat (n) @(posedge CLK);
    #2;
    RESET = 1'b0;
    base = tick;
    frame_rises.delete();
    frame_cslow.delete();
    vld_cyc.delete();
    vld_tn.delete();
    model_reset();
  endtask

  // Runs one frame with word w; returns at IDLE two cycles after CS_N rises.
  task automatic run_frame(input logic [15:0] w, output bit ok);
    int n0;
    n0 = frame_rises.size();
    next_w = w;
    for (int i = 0; i < 400 && frame_rises.size() == n0; i++) @(posedge CLK);
    repeat (2) @(posedge CLK);
    #2;
    ok = (frame_rises.size() > n0);
    model_frame(w);
  endtask

  task automatic test_reset();
    EN = 1'b1;
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #2;
      checks++;
      if ({CS_N, SCLK, TN, TN_VALID, FAULT} !== {1'b1, 1'b0, 12'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d got cs=%b sclk=%b tn=%0d vld=%b flt=%b exp 1 0 0 0 0",
                 i, CS_N, SCLK, TN, TN_VALID, FAULT);
      end
    end
    reset_dut(0);
  endtask

  task automatic test_nominal();
    bit ok1, ok2;
    reset_dut(2);
    run_frame(16'h0190, ok1);
    run_frame(16'h0190, ok2);
    checks++;
    if (!(ok1 && ok2) || vld_cyc.size() != 2) begin
      errors++;
      $display("FAIL nominal_frames got ok=%b%b pulses=%0d exp 11 2", ok1, ok2, vld_cyc.size());
    end else begin
      checks++;
      if (vld_cyc[0] != 141) begin errors++; $display("FAIL nominal_first_cycle got %0d exp 141", vld_cyc[0]); end
      checks++;
      if (vld_cyc[1] != 282) begin errors++; $display("FAIL nominal_second_cycle got %0d exp 282", vld_cyc[1]); end
      checks++;
      if (vld_tn[0] != 50) begin errors++; $display("FAIL nominal_tn got %0d exp 50", vld_tn[0]); end
      checks++;
      if (frame_rises[0] != 16) begin errors++; $display("FAIL nominal_sclk_rises got %0d exp 16", frame_rises[0]); end
      checks++;
      if (frame_cslow[0] != 132) begin errors++; $display("FAIL nominal_cs_low got %0d exp 132", frame_cslow[0]); end
    end
    checks++;
    if (FAULT !== 1'b0) begin errors++; $display("FAIL nominal_fault got %b exp 0", FAULT); end
  endtask

  task automatic test_clamp_sign();
    bit ok;
    logic [15:0] words [2];
    int fixed_exp [2];
    words[0] = 16'h0640; fixed_exp[0] = 100;
    words[1] = 16'h8008; fixed_exp[1] = 0;
    reset_dut(2);
    for (int i = 0; i < 2; i++) begin
      int n0;
      n0 = vld_cyc.size();
      run_frame(words[i], ok);
      checks++;
      if (!ok || vld_cyc.size() != n0 + 1 || int'(TN) != fixed_exp[i] || exp_tn != fixed_exp[i]) begin
        errors++;
        $display("FAIL clamp_sign_%0d got ok=%b pulses=%0d tn=%0d exp 1 %0d %0d",
                 i, ok, vld_cyc.size(), TN, n0 + 1, fixed_exp[i]);
      end
    end
  endtask

  task automatic test_fault();
    bit ok;
    logic [15:0] words [3];
    words[0] = 16'h0190; words[1] = 16'h0194; words[2] = 16'h00F0;
    reset_dut(2);
    for (int i = 0; i < 3; i++) begin
      int n0;
      n0 = vld_cyc.size();
      run_frame(words[i], ok);
      checks++;
      if (!ok || int'(TN) != exp_tn || FAULT !== exp_fault || vld_cyc.size() != n0 + int'(exp_vld)) begin
        errors++;
        $display("FAIL fault_seq_%0d got ok=%b tn=%0d flt=%b pulses=%0d exp 1 %0d %b %0d",
                 i, ok, TN, FAULT, vld_cyc.size(), exp_tn, exp_fault, n0 + int'(exp_vld));
      end
    end
    checks++;
    if (TN !== 12'd30 || FAULT !== 1'b0) begin
      errors++;
      $display("FAIL fault_recover got tn=%0d flt=%b exp 30 0", TN, FAULT);
    end
  endtask

  task automatic test_en_drop();
    bit ok;
    int nf;
    reset_dut(2);
    next_w = 16'h0258;
    for (int i = 0; i < 400 && rise_cnt < 8; i++) @(posedge CLK);
    #2;
    EN = 1'b0;
    for (int i = 0; i < 400 && frame_rises.size() == 0; i++) @(posedge CLK);
    repeat (2) @(posedge CLK);
    #2;
    model_frame(16'h0258);
    checks++;
    if (frame_rises.size() != 1 || vld_cyc.size() != 1 || int'(TN) != exp_tn) begin
      errors++;
      $display("FAIL en_drop_complete got frames=%0d pulses=%0d tn=%0d exp 1 1 %0d",
               frame_rises.size(), vld_cyc.size(), TN, exp_tn);
    end
    nf = frame_rises.size();
    repeat (300) @(posedge CLK);
    #2;
    checks++;
    if (frame_rises.size() != nf || cslow_cnt != 0 || CS_N !== 1'b1) begin
      errors++;
      $display("FAIL en_drop_idle got frames=%0d cslow=%0d cs=%b exp %0d 0 1", frame_rises.size(), cslow_cnt, CS_N, nf);
    end
    EN = 1'b1;
    run_frame(16'h0050, ok);
    checks++;
    if (!ok || int'(TN) != exp_tn || vld_cyc.size() != 2) begin
      errors++;
      $display("FAIL en_resume got ok=%b tn=%0d pulses=%0d exp 1 %0d 2", ok, TN, vld_cyc.size(), exp_tn);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int nv;
    reset_dut(2);
    run_frame(16'h0190, ok);
    next_w = 16'h0320;
    for (int i = 0; i < 400 && rise_cnt < 5; i++) @(posedge CLK);
    #2;
    nv = vld_cyc.size();
    RESET = 1'b1;
    @(posedge CLK);
    #2;
    checks++;
    if ({CS_N, SCLK, TN, TN_VALID, FAULT} !== {1'b1, 1'b0, 12'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_outputs got cs=%b sclk=%b tn=%0d vld=%b flt=%b exp 1 0 0 0 0",
               CS_N, SCLK, TN, TN_VALID, FAULT);
    end
    RESET = 1'b0;
    base = tick;
    model_reset();
    repeat (130) @(posedge CLK);
    #2;
    checks++;
    if (vld_cyc.size() != nv || TN !== 12'd0) begin
      errors++;
      $display("FAIL reset_mid_no_pulse got pulses=%0d tn=%0d exp %0d 0", vld_cyc.size(), TN, nv);
    end
    for (int i = 0; i < 40 && vld_cyc.size() == nv; i++) @(posedge CLK);
    #2;
    model_frame(16'h0320);
    checks++;
    if (vld_cyc.size() != nv + 1 || vld_cyc[vld_cyc.size()-1] != 141 || int'(TN) != exp_tn) begin
      errors++;
      $display("FAIL reset_mid_restart got pulses=%0d tn=%0d exp %0d at cycle 141 tn %0d",
               vld_cyc.size(), TN, nv + 1, exp_tn);
    end
  endtask

  task automatic test_random();
    bit ok;
    reset_dut(2);
    for (int i = 0; i < 12; i++) begin
      logic [15:0] w;
      logic [11:0] m;
      int n0, mode;
      mode = $urandom_range(0, 3);
      m = (mode == 2) ? 12'($urandom_range(0, 100)) : 12'($urandom);
      w = {(mode == 1), m, (mode == 0), 2'($urandom)};
      n0 = vld_cyc.size();
      run_frame(w, ok);
      checks++;
      if (!ok || int'(TN) != exp_tn || FAULT !== exp_fault || vld_cyc.size() != n0 + int'(exp_vld)) begin
        errors++;
        $display("FAIL random_%0d w=%h got ok=%b tn=%0d flt=%b pulses=%0d exp 1 %0d %b %0d",
                 i, w, ok, TN, FAULT, vld_cyc.size(), exp_tn, exp_fault, n0 + int'(exp_vld));
      end
    end
  endtask

  task automatic test_median();
    bit ok;
    logic [15:0] words [4];
    int fixed_exp [4];
    words[0] = 16'h00A0; words[1] = 16'h02D0; words[2] = 16'h00F0; words[3] = 16'h00C8;
    fixed_exp[0] = 20; fixed_exp[1] = 90; fixed_exp[2] = 30; fixed_exp[3] = MED ? 30 : 25;
    reset_dut(2);
    for (int i = 0; i < 4; i++) begin
      run_frame(words[i], ok);
      checks++;
      if (!ok || int'(TN) != fixed_exp[i] || exp_tn != fixed_exp[i]) begin
        errors++;
        $display("FAIL median_%0d got ok=%b tn=%0d model=%0d exp %0d", i, ok, TN, exp_tn, fixed_exp[i]);
      end
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (glitch != 0 || b2b != 0) begin
      errors++;
      $display("FAIL invariants got tn_changes_without_valid=%0d back_to_back=%0d exp 0 0", glitch, b2b);
    end
  endtask

  initial begin
    EN = 1'b1;
    RESET = 1'b1;
    test_reset();
    test_nominal();
    test_clamp_sign();
    test_fault();
    test_en_drop();
    test_reset_mid();
    test_random();
    test_median();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
